sta_symbol_tx: RTL and testbench



---
 rtl/sta_symbol_tx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sta_symbol_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_symbol_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sta_symbol_tx
//  Description : Station OFDM symbol formatter. It builds 52-beat symbols for
//                the channel estimator and emits them on out_stream. Each data
//                symbol has four polarity-scrambled pilots (sc 5/19/32/46), and
//                its other 48 slots carry data_stream beats unchanged. The two
//                L-LTF training symbols are optional and come before the data
//                symbols.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: STA_TX_LTF_EN. When it is defined, two LTF symbols
//  are sent before the data symbols. When it is undefined, the LTF state and
//  its logic are left out.
// ----------------------------------------------------------------------------
//  Ports
//    ap_clk, ap_rst_n        : clock, asynchronous active-low reset
//    ap_start                : frame start request (sampled only in IDLE)
//    num_symbols[15:0]       : data symbols per frame (latched at start)
//    modType[31:0]           : modulation code (bits 3:0 latched at start)
//    data_stream_T*          : AXI-Stream input of data subcarrier samples
//    out_stream_T*           : AXI-Stream output, {imag[63:32], real[31:0]}
//    ap_done / ap_idle       : one-cycle completion pulse / idle flag
//    ap_return[31:0]         : {mod[3:0], 12'b0, data symbols completed}
// ============================================================================
module sta_symbol_tx #(
  parameter int          AMP       = 16384,
  parameter logic [51:0] LTF_SIGNS = 52'b11110101001100000101011001_11110101100111111010110011
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  input  logic [15:0] num_symbols,
  input  logic [31:0] modType,
  input  logic [63:0] data_stream_TDATA,
  input  logic        data_stream_TVALID,
  output logic        data_stream_TREADY,
  output logic [63:0] out_stream_TDATA,
  output logic        out_stream_TVALID,
  input  logic        out_stream_TREADY,
  output logic        out_stream_TLAST,
  output logic        ap_done,
  output logic        ap_idle,
  output logic [31:0] ap_return
);

  localparam logic [31:0] c_amp_pos  = 32'(AMP);
  localparam logic [31:0] c_amp_neg  = 32'(-AMP);
  localparam logic [5:0]  c_sc_last  = 6'd51;
  localparam logic [5:0]  c_pilot_0  = 6'd5;
  localparam logic [5:0]  c_pilot_1  = 6'd19;
  localparam logic [5:0]  c_pilot_2  = 6'd32;
  localparam logic [5:0]  c_pilot_3  = 6'd46;
  localparam logic [6:0]  c_lfsr_seed = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef STA_TX_LTF_EN
    S_LTF  = 2'd1,
`endif
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [5:0]  r_sc_idx;
  logic [15:0] r_num_sym;
  logic [15:0] r_gen_sym;     // data symbols fully generated
  logic [15:0] r_sym_done;    // data symbols whose TLAST was accepted
  logic [3:0]  r_mod;
  logic [6:0]  r_lfsr;
  logic        r_gen_end;     // last beat of the frame is in the output slice
  logic [63:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_out_is_data; // slice holds a data-symbol beat (not LTF)
  logic        r_done;
  logic        r_idle;
`ifdef STA_TX_LTF_EN
  logic        r_ltf_sym;     // 0 = first LTF symbol, 1 = second
`endif

  logic        w_accept;
  logic        w_slot_free;
  logic        w_pilot_slot;
  logic        w_pilot_neg;
  logic        w_sc_last;
  logic        w_data_phase;
  logic        w_data_fire;
  logic        w_fire;
  logic [63:0] w_next_data;
  logic        w_lfsr_out;
  logic        w_unused;

  assign w_accept     = r_out_valid & out_stream_TREADY;
  // The slice can take a new beat when it is empty or drains this cycle.
  assign w_slot_free  = ~r_out_valid | out_stream_TREADY;
  assign w_sc_last    = (r_sc_idx == c_sc_last);
  assign w_pilot_slot = (r_sc_idx == c_pilot_0) | (r_sc_idx == c_pilot_1) |
                        (r_sc_idx == c_pilot_2) | (r_sc_idx == c_pilot_3);
  // Scrambler output x^7 xor x^4; a 1 means the symbol's pilots are inverted.
  assign w_lfsr_out   = r_lfsr[6] ^ r_lfsr[3];
  // Base pattern {+,+,+,-}: only sc 46 is negative before the polarity is applied.
  assign w_pilot_neg  = (r_sc_idx == c_pilot_3) ^ w_lfsr_out;

  assign w_data_phase = (r_state == S_DATA) & ~r_gen_end;
  assign data_stream_TREADY = w_data_phase & ~w_pilot_slot & w_slot_free;
  // A data slot with no input beat stalls until the input beat arrives.
  assign w_data_fire  = w_data_phase & w_slot_free & (w_pilot_slot | data_stream_TVALID);

`ifdef STA_TX_LTF_EN
  logic w_ltf_fire;
  assign w_ltf_fire = (r_state == S_LTF) & ~r_gen_end & w_slot_free;
  assign w_fire     = w_data_fire | w_ltf_fire;
  assign w_unused   = ^modType[31:4];

  always_comb begin
    w_next_data = 64'd0;
    if (r_state == S_LTF)
      w_next_data = {32'd0, LTF_SIGNS[r_sc_idx] ? c_amp_pos : c_amp_neg};
    else if (w_pilot_slot)
      w_next_data = {32'd0, w_pilot_neg ? c_amp_neg : c_amp_pos};
    else
      w_next_data = data_stream_TDATA;
  end
`else
  assign w_fire   = w_data_fire;
  assign w_unused = ^{modType[31:4], LTF_SIGNS};

  always_comb begin
    w_next_data = 64'd0;
    if (w_pilot_slot)
      w_next_data = {32'd0, w_pilot_neg ? c_amp_neg : c_amp_pos};
    else
      w_next_data = data_stream_TDATA;
  end
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= S_IDLE;
      r_sc_idx      <= 6'd0;
      r_num_sym     <= 16'd0;
      r_gen_sym     <= 16'd0;
      r_sym_done    <= 16'd0;
      r_mod         <= 4'd0;
      r_lfsr        <= c_lfsr_seed;
      r_gen_end     <= 1'b0;
      r_out_data    <= 64'd0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_is_data <= 1'b0;
      r_done        <= 1'b0;
      r_idle        <= 1'b1;
`ifdef STA_TX_LTF_EN
      r_ltf_sym     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      // Output register slice
      if (w_fire) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_next_data;
        r_out_last    <= w_sc_last;
        r_out_is_data <= (r_state == S_DATA);
      end else if (w_accept) begin
        r_out_valid   <= 1'b0;
      end

      if (w_accept && r_out_last && r_out_is_data)
        r_sym_done <= r_sym_done + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_num_sym  <= num_symbols;
            r_mod      <= modType[3:0];
            r_sym_done <= 16'd0;
            r_gen_sym  <= 16'd0;
            r_lfsr     <= c_lfsr_seed;
            r_sc_idx   <= 6'd0;
            r_gen_end  <= 1'b0;
            r_idle     <= 1'b0;
`ifdef STA_TX_LTF_EN
            r_ltf_sym  <= 1'b0;
            r_state    <= S_LTF;
`else
            if (num_symbols == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
`endif
          end
        end

`ifdef STA_TX_LTF_EN
        S_LTF: begin
          if (r_gen_end) begin
            // Only reached with zero data symbols: wait for the last LTF beat.
            if (w_accept) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_ltf_fire) begin
            r_sc_idx <= w_sc_last ? 6'd0 : r_sc_idx + 6'd1;
            if (w_sc_last) begin
              if (!r_ltf_sym)
                r_ltf_sym <= 1'b1;
              else if (r_num_sym == 16'd0)
                r_gen_end <= 1'b1;
              else
                r_state <= S_DATA;
            end
          end
        end
`endif

        S_DATA: begin
          if (r_gen_end) begin
            // Hold DATA until the final TLAST leaves the slice.
            if (w_accept) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_data_fire) begin
            r_sc_idx <= w_sc_last ? 6'd0 : r_sc_idx + 6'd1;
            if (w_sc_last) begin
              r_lfsr    <= {r_lfsr[5:0], w_lfsr_out};
              r_gen_sym <= r_gen_sym + 16'd1;
              if (r_gen_sym + 16'd1 == r_num_sym)
                r_gen_end <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign out_stream_TDATA  = r_out_data;
  assign out_stream_TVALID = r_out_valid;
  assign out_stream_TLAST  = r_out_last;
  assign ap_done           = r_done;
  assign ap_idle           = r_idle;
  assign ap_return         = {r_mod, 12'd0, r_sym_done};

endmodule
`default_nettype wire

// File: tb/tb_sta_symbol_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sta_symbol_tx
//  Description : Directed self-checking bench for sta_symbol_tx. It works with
//                or without STA_TX_LTF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sta_symbol_tx;

  localparam int AMP = 16384;
`ifdef STA_TX_LTF_EN
  localparam int LTF_SYMS = 2;
`else
  localparam int LTF_SYMS = 0;
`endif

  // 802.11 L-LTF signs, subcarrier -26..-1, +1..+26
  int ltf_ref[52] = '{1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,
                      1,-1,-1,1,1,-1,1,-1,1,-1,-1,-1,-1,-1,1,1,-1,-1,1,-1,1,-1,1,1,1,1};
  // 802.11 pilot polarity sequence p0..p7
  int pol_ref[8] = '{1,1,1,1,-1,-1,-1,1};

  logic        ap_clk, ap_rst_n, ap_start;
  logic [15:0] num_symbols;
  logic [31:0] modType;
  logic [63:0] data_stream_TDATA;
  logic        data_stream_TVALID, data_stream_TREADY;
  logic [63:0] out_stream_TDATA;
  logic        out_stream_TVALID, out_stream_TREADY, out_stream_TLAST;
  logic        ap_done, ap_idle;
  logic [31:0] ap_return;

  sta_symbol_tx dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .num_symbols(num_symbols), .modType(modType),
    .data_stream_TDATA(data_stream_TDATA), .data_stream_TVALID(data_stream_TVALID),
    .data_stream_TREADY(data_stream_TREADY),
    .out_stream_TDATA(out_stream_TDATA), .out_stream_TVALID(out_stream_TVALID),
    .out_stream_TREADY(out_stream_TREADY), .out_stream_TLAST(out_stream_TLAST),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_return(ap_return)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];
  int  dk = 1;          // next data beat number presented
  int  gap_at = 0;      // data beat number preceded by a 5-cycle gap
  int  gap_left = 0;
  bit  took = 0;
  bit  bp_en = 0;
  int  done_cnt = 0;
  int  low_cnt = 0;
  int  hold_err = 0;
  bit  seen_first = 0;
  bit  hold_prev = 0;
  logic [64:0] hold_val = '0;

  // Data source: beat k carries real=k, imag=-k.
  always @(negedge ap_clk) took = data_stream_TVALID && data_stream_TREADY;
  always @(posedge ap_clk) begin
    #1;
    if (took) begin
      dk++;
      if (dk == gap_at) gap_left = 5;
    end
    if (gap_left > 0) begin
      data_stream_TVALID = 1'b0;
      gap_left--;
    end else begin
      data_stream_TVALID = 1'b1;
    end
    data_stream_TDATA = {32'(-dk), 32'(dk)};
    out_stream_TREADY = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Output monitor
  always @(negedge ap_clk) begin
    if (out_stream_TVALID && out_stream_TREADY)
      got_q.push_back({out_stream_TLAST, out_stream_TDATA});
    if (ap_rst_n && hold_prev &&
        (!out_stream_TVALID || {out_stream_TLAST, out_stream_TDATA} !== hold_val))
      hold_err++;
    hold_prev = out_stream_TVALID && !out_stream_TREADY;
    hold_val  = {out_stream_TLAST, out_stream_TDATA};
    if (ap_done) done_cnt++;
    if (out_stream_TVALID) seen_first = 1;
    else if (seen_first && !ap_idle && !ap_done) low_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int nsym);
    int k = 1;
    exp_q.delete();
    for (int l = 0; l < LTF_SYMS; l++)
      for (int sc = 0; sc < 52; sc++)
        exp_q.push_back({sc == 51, 32'd0, ltf_ref[sc] > 0 ? 32'(AMP) : 32'(-AMP)});
    for (int s = 0; s < nsym; s++)
      for (int sc = 0; sc < 52; sc++) begin
        if (sc == 5 || sc == 19 || sc == 32 || sc == 46) begin
          int v = (sc == 46 ? -1 : 1) * pol_ref[s] * AMP;
          exp_q.push_back({sc == 51, 32'd0, 32'(v)});
        end else begin
          exp_q.push_back({sc == 51, 32'(-k), 32'(k)});
          k++;
        end
      end
  endtask

  task automatic compare_frame(input string tag);
    int bad = -1;
    check({tag, " beat count"}, 65'(got_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        bad = i;
        break;
      end
    if (bad >= 0)
      $display("  %s first differing beat %0d: got %h want %h", tag, bad, got_q[bad], exp_q[bad]);
    check({tag, " beat sequence"}, 65'(bad), 65'(-1));
  endtask

  task automatic start_frame(input logic [15:0] ns, input logic [31:0] mt, input bit chk_lat);
    got_q.delete();
    seen_first = 0;
    low_cnt = 0;
    hold_err = 0;
    dk = 1;
    @(posedge ap_clk); #2;
    num_symbols = ns;
    modType = mt;
    ap_start = 1'b1;
    @(posedge ap_clk); #2;
    ap_start = 1'b0;
    if (chk_lat) begin
      check("latency cycle after accept", 65'(out_stream_TVALID), 65'(0));
      @(posedge ap_clk); #2;
      check("latency first beat", 65'(out_stream_TVALID), 65'(1));
    end
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (!ap_done && cyc < limit) begin
      @(negedge ap_clk);
      cyc++;
    end
    check({tag, " done timeout"}, 65'(!ap_done), 65'(0));
    @(negedge ap_clk);
    @(negedge ap_clk);
    #1;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int c = 0;
    while (got_q.size() < n && c < 3000) begin
      @(negedge ap_clk);
      c++;
    end
    check({tag, " reach beat"}, 65'(got_q.size() >= n), 65'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " TVALID"}, 65'(out_stream_TVALID), 65'(0));
    check({tag, " TLAST"},  65'(out_stream_TLAST),  65'(0));
    check({tag, " TDATA"},  65'(out_stream_TDATA),  65'(0));
    check({tag, " in TREADY"}, 65'(data_stream_TREADY), 65'(0));
    check({tag, " ap_done"}, 65'(ap_done), 65'(0));
    check({tag, " ap_idle"}, 65'(ap_idle), 65'(1));
    check({tag, " ap_return"}, 65'(ap_return), 65'(0));
  endtask

  initial begin
    int cyc;
    int d0;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    num_symbols = 16'd0;
    modType = 32'd0;
    data_stream_TDATA = 64'd0;
    data_stream_TVALID = 1'b0;
    out_stream_TREADY = 1'b1;
    repeat (3) @(posedge ap_clk);
    #3;
    check_reset_outputs("reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);

    // A: one data symbol, full throughput
    build_exp(1);
    d0 = done_cnt;
    start_frame(16'd1, 32'h0000_0005, 1'b1);
    wait_done("A", 1000, cyc);
    compare_frame("A");
    check("A pilot sc5",  65'(got_q[LTF_SYMS*52 + 5][31:0]),  65'(32'h0000_4000));
    check("A pilot sc46", 65'(got_q[LTF_SYMS*52 + 46][31:0]), 65'(32'hFFFF_C000));
    check("A done pulses", 65'(done_cnt - d0), 65'(1));
    check("A ap_return", 65'(ap_return), 65'(32'h5000_0001));
    check("A valid gaps", 65'(low_cnt), 65'(0));
    check("A ap_idle", 65'(ap_idle), 65'(1));

    // B: three symbols, random output backpressure
    bp_en = 1;
    build_exp(3);
    d0 = done_cnt;
    start_frame(16'd3, 32'h0000_0003, 1'b1);
    wait_done("B", 3000, cyc);
    bp_en = 0;
    compare_frame("B");
    check("B hold stability", 65'(hold_err), 65'(0));
    check("B done pulses", 65'(done_cnt - d0), 65'(1));
    check("B ap_return", 65'(ap_return), 65'(32'h3000_0003));

    // C: data input gap of 5 cycles at sc 10
    gap_at = 10;
    build_exp(1);
    start_frame(16'd1, 32'h0000_0001, 1'b0);
    wait_done("C", 1000, cyc);
    gap_at = 0;
    compare_frame("C");
    check("C stall cycles", 65'(low_cnt), 65'(5));
    check("C sc10 beat", 65'(got_q[LTF_SYMS*52 + 10]), {1'b0, 32'(-10), 32'd10});

    // D: ap_start pulsed mid-frame is ignored
    build_exp(2);
    d0 = done_cnt;
    start_frame(16'd2, 32'h0000_0002, 1'b0);
    wait_beats("D", LTF_SYMS*52 + 60);
    @(posedge ap_clk); #2;
    num_symbols = 16'd7;
    ap_start = 1'b1;
    @(posedge ap_clk); #2;
    ap_start = 1'b0;
    wait_done("D", 2000, cyc);
    repeat (5) @(negedge ap_clk);
    #1;
    compare_frame("D");
    check("D done pulses", 65'(done_cnt - d0), 65'(1));
    check("D symbol count", 65'(ap_return[15:0]), 65'(2));
    check("D stays idle", 65'(ap_idle), 65'(1));
    check("D no restart", 65'(out_stream_TVALID), 65'(0));

    // E: zero data symbols
    build_exp(0);
    d0 = done_cnt;
    start_frame(16'd0, 32'h0000_0009, 1'b0);
    wait_done("E", 1000, cyc);
    check("E done latency", 65'(cyc <= LTF_SYMS*52 + 2), 65'(1));
    compare_frame("E");
    check("E done pulses", 65'(done_cnt - d0), 65'(1));
    check("E ap_return", 65'(ap_return), 65'(32'h9000_0000));

    // F: reset at beat 30 of data symbol 2, then a clean six-symbol frame
    start_frame(16'd6, 32'h0000_0006, 1'b0);
    wait_beats("F", LTF_SYMS*52 + 52 + 30);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-frame reset");
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);
    build_exp(6);
    d0 = done_cnt;
    start_frame(16'd6, 32'h0000_000C, 1'b1);
    wait_done("F", 3000, cyc);
    compare_frame("F");
    check("F done pulses", 65'(done_cnt - d0), 65'(1));
    check("F ap_return", 65'(ap_return), 65'(32'hC000_0006));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
